// File: rtl/bus_pkg.sv
// Shared constants for the CPU bus: source indices, init FSM states, sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

  // Register sources occupy the low out_sel bits.
  localparam int SRC_R0  = 0;
  localparam int SRC_R1  = 1;
  localparam int SRC_R2  = 2;
  localparam int SRC_R3  = 3;
  localparam int SRC_R4  = 4;
  localparam int SRC_R5  = 5;
  localparam int SRC_R6  = 6;
  localparam int SRC_R7  = 7;
  localparam int SRC_R8  = 8;
  localparam int SRC_R9  = 9;
  localparam int SRC_R10 = 10;
  localparam int SRC_R11 = 11;
  localparam int SRC_R12 = 12;
  localparam int SRC_R13 = 13;
  localparam int SRC_R14 = 14;
  localparam int SRC_R15 = 15;

  // External sources follow the registers; ext_in lane = SRC_x - SRC_HI.
  localparam int SRC_HI  = 16;
  localparam int SRC_LO  = 17;
  localparam int SRC_ZHI = 18;
  localparam int SRC_ZLO = 19;
  localparam int SRC_PC  = 20;
  localparam int SRC_IR  = 21;
  localparam int SRC_MDR = 22;
  localparam int SRC_IN  = 23;
  localparam int SRC_C   = 24;
  localparam int SRC_Y   = 25;
  localparam int SRC_MAR = 26;

  localparam int NREGS_DEF = 16;
  localparam int NEXT_DEF  = 11;

  // Total number of bus drivers for a given register/external split.
  function automatic int nsrc(input int nregs, input int next);
    return nregs + next;
  endfunction

  localparam int NSRC_DEF = nsrc(NREGS_DEF, NEXT_DEF);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } init_state_e;

endpackage

// File: rtl/bus_regfile_if.sv
// Control-unit <-> register-file/bus bundle: drive enables, load enables, status.
// Latency: n/a (wiring only).
// Backpressure: none; every enable is acted on in the cycle it is presented.
interface bus_regfile_if
  import bus_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = NREGS_DEF,
  parameter int NEXT  = NEXT_DEF,
  parameter int CNT_W = 8
);

  logic [nsrc(NREGS, NEXT)-1:0] out_sel;
  logic [NEXT*WIDTH-1:0]        ext_in;
  logic [NREGS-1:0]             in_en;
  logic                         init_start;
  logic [WIDTH-1:0]             bus_out;
  logic                         conflict;
  logic [CNT_W-1:0]             conflict_count;
  logic                         init_busy;

  // Control unit side.
  modport master (
    output out_sel, ext_in, in_en, init_start,
    input  bus_out, conflict, conflict_count, init_busy
  );

  // Register file side.
  modport slave (
    input  out_sel, ext_in, in_en, init_start,
    output bus_out, conflict, conflict_count, init_busy
  );

endinterface

// File: rtl/bus_mux.sv
// Priority one-hot bus selector (lowest set index wins) with multi-driver detect.
// Latency: purely combinational.
// Backpressure: none.
module bus_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 27
) (
  input  logic [NSRC-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src_dat,
  output logic [WIDTH-1:0]      bus_dat,
  output logic                  conflict
);

  logic found;
  logic seen;

  // Scan upward; the first asserted select claims the bus, no select gives 0.
  always_comb begin
    bus_dat = '0;
    found   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel[i] && !found) begin
        bus_dat = src_dat[i*WIDTH +: WIDTH];
        found   = 1'b1;
      end
    end
  end

  // A second asserted select after any earlier one means popcount > 1.
  always_comb begin
    seen     = 1'b0;
    conflict = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      conflict = conflict | (seen & sel[i]);
      seen     = seen | sel[i];
    end
  end

endmodule

// File: rtl/bus_regfile.sv
// CPU datapath core: register file, priority bus mux, write-back, index-load sweep.
// Latency: bus_out/conflict combinational (BUS_REG=0) or 1 cycle (BUS_REG=1).
// Backpressure: none; init_start and in_en are ignored while a sweep runs.
module bus_regfile
  import bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int NEXT    = 11,
  parameter int BUS_REG = 0,
  parameter int R0_ZERO = 0,
  parameter int CNT_W   = 8
) (
  input logic          clk,
  input logic          reset,
  bus_regfile_if.slave bif
);

  localparam int NSRC = nsrc(NREGS, NEXT);
  localparam int KW   = $clog2(NREGS);
  localparam logic [KW-1:0] K_LAST = KW'(NREGS - 1);

  logic [WIDTH-1:0]      regs_q [NREGS];
  logic [NSRC*WIDTH-1:0] src_dat;
  logic [WIDTH-1:0]      mux_dat;
  logic                  mux_conflict;
  logic [WIDTH-1:0]      bus_val;
  logic                  conflict_val;
  logic [CNT_W-1:0]      cnt_q;
  init_state_e           state_q;
  logic [KW-1:0]         k_q;

  // Flatten registers and external lanes into one source vector; R0 reads 0 when hardwired.
  always_comb begin
    src_dat = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!((R0_ZERO != 0) && (i == 0))) begin
        src_dat[i*WIDTH +: WIDTH] = regs_q[i];
      end
    end
    src_dat[NREGS*WIDTH +: NEXT*WIDTH] = bif.ext_in;
  end

  bus_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) u_mux (
    .sel      (bif.out_sel),
    .src_dat  (src_dat),
    .bus_dat  (mux_dat),
    .conflict (mux_conflict)
  );

  generate
    if (BUS_REG != 0) begin : g_bus_reg
      logic [WIDTH-1:0] bus_q;
      logic             conflict_q;

      // Register the bus and its conflict flag together so they stay aligned.
      always_ff @(posedge clk) begin
        if (reset) begin
          bus_q      <= '0;
          conflict_q <= 1'b0;
        end else begin
          bus_q      <= mux_dat;
          conflict_q <= mux_conflict;
        end
      end

      assign bus_val      = bus_q;
      assign conflict_val = conflict_q;
    end else begin : g_bus_comb
      assign bus_val      = mux_dat;
      assign conflict_val = mux_conflict;
    end
  endgenerate

  // Register file: sweep writes its index, otherwise every enabled register takes the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      if (!((R0_ZERO != 0) && (k_q == '0))) begin
        regs_q[k_q] <= WIDTH'(k_q);
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bif.in_en[i] && !((R0_ZERO != 0) && (i == 0))) begin
          regs_q[i] <= bus_val;
        end
      end
    end
  end

  // Count cycles with a reported conflict, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (conflict_val && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Init sweep: walk k from 0 to NREGS-1, one register per cycle, then return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bif.init_start) begin
            state_q <= SWEEP;
            k_q     <= '0;
          end
        end
        SWEEP: begin
          if (k_q == K_LAST) begin
            state_q <= IDLE;
            k_q     <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          k_q     <= '0;
        end
      endcase
    end
  end

  assign bif.bus_out        = bus_val;
  assign bif.conflict       = conflict_val;
  assign bif.conflict_count = cnt_q;
  assign bif.init_busy      = (state_q == SWEEP);

endmodule

// File: tb/tb_bus_regfile.sv
// Directed bench for bus_regfile: a default instance and a BUS_REG=1/R0_ZERO=1/CNT_W=2 instance.
// Latency: instance 0 checked combinationally, instance 1 one cycle after selection.
// Backpressure: n/a.
module tb_bus_regfile;
  import bus_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int NEXT  = 11;
  localparam int NSRC  = NREGS + NEXT;

  logic                  clk;
  logic                  reset;
  logic [NSRC-1:0]       out_sel;
  logic [NEXT*WIDTH-1:0] ext_in;
  logic [NREGS-1:0]      in_en;
  logic                  init_start;

  int vectors;
  int miscompares;
  int n0;
  int n1;

  bus_regfile_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NEXT(NEXT), .CNT_W(8)) i0 ();
  bus_regfile_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NEXT(NEXT), .CNT_W(2)) i1 ();

  assign i0.out_sel    = out_sel;
  assign i0.ext_in     = ext_in;
  assign i0.in_en      = in_en;
  assign i0.init_start = init_start;
  assign i1.out_sel    = out_sel;
  assign i1.ext_in     = ext_in;
  assign i1.in_en      = in_en;
  assign i1.init_start = init_start;

  bus_regfile #(
    .WIDTH(WIDTH), .NREGS(NREGS), .NEXT(NEXT), .BUS_REG(0), .R0_ZERO(0), .CNT_W(8)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bif   (i0.slave)
  );

  bus_regfile #(
    .WIDTH(WIDTH), .NREGS(NREGS), .NEXT(NEXT), .BUS_REG(1), .R0_ZERO(1), .CNT_W(2)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bif   (i1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sel_one(input int idx);
    out_sel      = '0;
    out_sel[idx] = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    out_sel     = '0;
    ext_in      = '0;
    in_en       = '0;
    init_start  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state.
    chk("rst_bus0", i0.bus_out, 0);
    chk("rst_conf0", i0.conflict, 0);
    chk("rst_cnt0", i0.conflict_count, 0);
    chk("rst_busy0", i0.init_busy, 0);
    chk("rst_bus1", i1.bus_out, 0);
    chk("rst_cnt1", i1.conflict_count, 0);
    chk("rst_busy1", i1.init_busy, 0);
    sel_one(SRC_R5);
    #1;
    chk("rst_r5_0", i0.bus_out, 0);
    tick();
    chk("rst_r5_1", i1.bus_out, 0);

    // Init sweep: busy for exactly NREGS cycles.
    out_sel    = '0;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int it = 0; it < 20; it++) begin
      n0 += int'(i0.init_busy);
      n1 += int'(i1.init_busy);
      tick();
    end
    chk("sweep_len0", 64'(n0), 16);
    chk("sweep_len1", 64'(n1), 16);

    // Every register holds its own index (R0 hardwired 0 on instance 1).
    for (int n = 0; n < NREGS; n++) begin
      sel_one(n);
      #1;
      chk("idx_rd0", i0.bus_out, 64'(n));
      tick();
      chk("idx_rd1", i1.bus_out, (n == 0) ? 64'd0 : 64'(n));
    end

    // MDR -> R7 write-back.
    ext_in[(SRC_MDR-SRC_HI)*WIDTH +: WIDTH] = 32'h0000_0024;
    sel_one(SRC_MDR);
    tick();
    chk("mdr_bus0", i0.bus_out, 64'h24);
    chk("mdr_bus1", i1.bus_out, 64'h24);
    in_en[7] = 1'b1;
    tick();
    in_en = '0;
    sel_one(SRC_R7);
    #1;
    chk("r7_rd0", i0.bus_out, 64'h24);
    tick();
    chk("r7_rd1", i1.bus_out, 64'h24);

    // Conflict: R3|R9|HI, lowest index wins, counter runs and saturates at 3 on CNT_W=2.
    out_sel          = '0;
    out_sel[SRC_R3]  = 1'b1;
    out_sel[SRC_R9]  = 1'b1;
    out_sel[SRC_HI]  = 1'b1;
    #1;
    chk("cf_bus0", i0.bus_out, 3);
    chk("cf_flag0", i0.conflict, 1);
    chk("cf_cnt0_init", i0.conflict_count, 0);
    tick();
    chk("cf_bus1", i1.bus_out, 3);
    chk("cf_flag1", i1.conflict, 1);
    chk("cf_cnt1_first", i1.conflict_count, 0);
    chk("cf_cnt0_one", i0.conflict_count, 1);
    tick();
    tick();
    tick();
    tick();
    chk("cf_cnt0_five", i0.conflict_count, 5);
    chk("cf_cnt1_sat", i1.conflict_count, 3);
    out_sel = '0;
    tick();
    tick();
    chk("cf_hold0", i0.conflict_count, 5);
    chk("cf_hold1", i1.conflict_count, 3);
    chk("cf_clr0", i0.conflict, 0);
    chk("cf_clr1", i1.conflict, 0);

    // Reset on sweep cycle 5 aborts the sweep and clears everything.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int it = 0; it < 5; it++) tick();
    chk("mid_busy0", i0.init_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy0", i0.init_busy, 0);
    chk("abort_busy1", i1.init_busy, 0);
    chk("abort_cnt0", i0.conflict_count, 0);
    sel_one(SRC_R7);
    #1;
    chk("abort_r7", i0.bus_out, 0);
    sel_one(SRC_R3);
    #1;
    chk("abort_r3", i0.bus_out, 0);
    out_sel = '0;

    // Fresh sweep; a second init_start and an all-ones in_en mid-sweep are ignored.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n0 = 0;
    n1 = 0;
    for (int it = 0; it < 20; it++) begin
      n0 += int'(i0.init_busy);
      n1 += int'(i1.init_busy);
      init_start = (it == 3);
      in_en      = (it == 5) ? '1 : '0;
      tick();
    end
    init_start = 1'b0;
    in_en      = '0;
    chk("resweep_len0", 64'(n0), 16);
    chk("resweep_len1", 64'(n1), 16);
    sel_one(SRC_R12);
    #1;
    chk("resweep_r12_0", i0.bus_out, 12);
    tick();
    chk("resweep_r12_1", i1.bus_out, 12);

    // Broadcast write of DEADBEEF from the IN lane into every register.
    ext_in[(SRC_IN-SRC_HI)*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    sel_one(SRC_IN);
    tick();
    chk("bc_bus0", i0.bus_out, 64'hDEAD_BEEF);
    chk("bc_bus1", i1.bus_out, 64'hDEAD_BEEF);
    in_en = '1;
    tick();
    in_en = '0;
    for (int n = 0; n < NREGS; n++) begin
      sel_one(n);
      #1;
      chk("bc_rd0", i0.bus_out, 64'hDEAD_BEEF);
      tick();
      chk("bc_rd1", i1.bus_out, (n == 0) ? 64'd0 : 64'hDEAD_BEEF);
    end

    // Nothing selected drives zero.
    out_sel = '0;
    #1;
    chk("none_bus0", i0.bus_out, 0);
    tick();
    chk("none_bus1", i1.bus_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
